imem_loader: RTL and testbench

Boot-time writer for the dual 16-bit SPRAM instruction store. It is the write-side counterpart of the core's read-only fetch path.
- Accepts a byte stream (valid/ready) from the host link (UART/SPI bridge).
- Assembles little-endian 32-bit words and writes each word into the hi/lo SPRAM halves in a single cycle.
- Drives the SPRAM stand-by request and holds the core in reset until loading finishes.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-store boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam int         BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam logic [3:0] MEM_BE_ALL     = 4'hF;

  function automatic logic last_byte(input logic [BYTE_IDX_W-1:0] idx);
    return idx == BYTE_IDX_W'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler; the first accepted byte lands in bits [7:0].
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int SH_W = 8 * (BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [SH_W-1:0]       shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 1'b1;
      shreg    <= {byte_in, shreg[SH_W-1:8]};
    end
  end

  // The final byte is merged combinationally so the word is usable on its accept edge.
  assign word       = {byte_in, shreg};
  assign word_valid = accept && last_byte(byte_idx);

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the dual 16-bit SPRAM instruction store.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAKE_CYCLES = 3,
  parameter int MAX_WORDS   = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din_hi,
  output logic [15:0]       mem_din_lo,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic              ls_req,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  // One extra bit so a count of exactly 2**ADDR_W words is representable.
  localparam int                CNT_W     = ADDR_W + 1;
  localparam int                WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  word_cnt_nx;
  logic [CNT_W-1:0]  n_words;
  logic [WAKE_W-1:0] wake_cnt;
  logic              byte_accept;
  logic              pk_clear;
  logic              pk_valid;
  logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_acc;
`endif

  assign byte_accept = in_valid && in_ready;
  assign pk_clear    = (state == IDLE) && start;
  assign word_cnt_nx = word_cnt + 1'b1;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .accept     (byte_accept),
    .byte_in    (in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_din_hi <= '0;
      mem_din_lo <= '0;
      ls_req     <= 1'b1;
      core_hold  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_q     <= '0;
      word_cnt   <= '0;
      n_words    <= '0;
      wake_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_acc   <= '0;
`endif
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      case (state)
        IDLE: begin
          ls_req    <= 1'b1;
          core_hold <= 1'b0;
          in_ready  <= 1'b0;
          if (start) begin
            addr_q    <= base_addr;
            err       <= 1'b0;
            word_cnt  <= '0;
            wake_cnt  <= '0;
            ls_req    <= 1'b0;
            core_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc  <= '0;
`endif
            state     <= WAKE;
          end
        end

        // SPRAM stand-by exit: no bytes are taken until the macros are awake.
        WAKE: begin
          if (wake_cnt == WAKE_LAST) begin
            state    <= LEN;
            in_ready <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end

        LEN: begin
          if (pk_valid) begin
            if (pk_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CSUM;
`else
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
`endif
            end else if (pk_word > 32'(MAX_WORDS)) begin
              err      <= 1'b1;
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              n_words  <= pk_word[CNT_W-1:0];
              state    <= DATA;
            end
          end
        end

        DATA: begin
          if (pk_valid) begin
            state      <= WRITE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b1;
            mem_be     <= MEM_BE_ALL;
            mem_addr   <= addr_q;
            mem_din_hi <= pk_word[31:16];
            mem_din_lo <= pk_word[15:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= csum_acc + pk_word;
`endif
          end
        end

        // Write strobe is live this cycle; address wraps naturally at ADDR_W bits.
        WRITE: begin
          addr_q   <= addr_q + 1'b1;
          word_cnt <= word_cnt_nx;
          if (word_cnt_nx == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CSUM;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            done     <= 1'b1;
`endif
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (pk_valid) begin
            in_ready <= 1'b0;
            state    <= DONE;
            done     <= 1'b1;
            if (pk_word != csum_acc) begin
              err <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          state     <= IDLE;
          ls_req    <= 1'b1;
          core_hold <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, random loads, and reset/start corner cases.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W      = 14;
  localparam int WAKE_CYCLES = 3;
  localparam int MAX_WORDS   = 16384;
  localparam int NV          = 5;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [31:0]       n;
    logic [31:0]       w0;
    logic [31:0]       w1;
    logic              exp_err;
    int                exp_nwr;
    logic [ADDR_W-1:0] a0;
    logic [15:0]       hi0;
    logic [15:0]       lo0;
    logic [ADDR_W-1:0] a1;
    logic [15:0]       hi1;
    logic [15:0]       lo1;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din_hi;
  logic [15:0]       mem_din_lo;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic              ls_req;
  logic              core_hold;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;
  int first_wr_cyc;
  int done_cnt;
  bit in_load;
  logic [15:0] last_hi, last_lo;

  logic [31:0]       stim_words[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [15:0]       wr_hi_q[$];
  logic [15:0]       wr_lo_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [15:0]       exp_hi_q[$];
  logic [15:0]       exp_lo_q[$];
  vec_t              vecs[NV];
`ifdef IMEM_LOADER_CHECKSUM_EN
  bit csum_corrupt = 1'b0;
`endif

  imem_loader #(
    .ADDR_W      (ADDR_W),
    .WAKE_CYCLES (WAKE_CYCLES),
    .MAX_WORDS   (MAX_WORDS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_din_hi (mem_din_hi),
    .mem_din_lo (mem_din_lo),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .ls_req     (ls_req),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write capture and always-on output rules, sampled mid-cycle.
  initial begin
    last_hi = '0;
    last_lo = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mem_be", 32'(mem_be), mem_we ? 32'hF : 32'h0);
        if (mem_we) begin
          wr_addr_q.push_back(mem_addr);
          wr_hi_q.push_back(mem_din_hi);
          wr_lo_q.push_back(mem_din_lo);
          last_hi = mem_din_hi;
          last_lo = mem_din_lo;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end else begin
          chk("din_hold", {mem_din_hi, mem_din_lo}, {last_hi, last_lo});
        end
        if (in_load) begin
          chk("ls_req_busy", 32'(ls_req), 32'd0);
          chk("core_hold_busy", 32'(core_hold), 32'd1);
        end
        if (done) begin
          done_cnt++;
          in_load = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    int guard;
    n = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_din"}, {mem_din_hi, mem_din_lo}, 32'd0);
    chk({tag, "_ls_req"}, 32'(ls_req), 32'd1);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic run_load(input logic [ADDR_W-1:0] base, input logic [31:0] n, input int gap,
                          input bit mid_start, input logic exp_err, input string tag);
    int guard;
    int nw;
    bit direct_end;
    nw = (n > 32'(MAX_WORDS)) ? 0 : int'(n);
    wr_addr_q.delete();
    wr_hi_q.delete();
    wr_lo_q.delete();
    done_cnt     = 0;
    first_wr_cyc = -1;
    base_addr = base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    start_cyc = cyc;
    in_load   = 1'b1;
    chk({tag, "_err_clr"}, 32'(err), 32'd0);
    chk({tag, "_ls_req_wake"}, 32'(ls_req), 32'd0);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gap);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) send_byte(stim_words[w][8*k +: 8], gap);
      if (mid_start && w == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n <= 32'(MAX_WORDS)) begin
      logic [31:0] sum;
      sum = csum_corrupt ? 32'd1 : 32'd0;
      for (int w = 0; w < nw; w++) sum = sum + stim_words[w];
      for (int k = 0; k < 4; k++) send_byte(sum[8*k +: 8], gap);
    end
    direct_end = 1'b1;
`else
    direct_end = (nw == 0);
`endif
    if (direct_end) chk({tag, "_done_now"}, 32'(done), 32'd1);
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_ls_req_idle"}, 32'(ls_req), 32'd1);
    chk({tag, "_core_hold_idle"}, 32'(core_hold), 32'd0);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd0);
    if (nw > 0)
      chk({tag, "_wake_lat"}, 32'(first_wr_cyc - start_cyc >= WAKE_CYCLES + 4), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
      chk($sformatf("%s_hi%0d", tag, i), 32'(wr_hi_q[i]), 32'(exp_hi_q[i]));
      chk($sformatf("%s_lo%0d", tag, i), 32'(wr_lo_q[i]), 32'(exp_lo_q[i]));
    end
  endtask

  task automatic load_vec(input int v);
    stim_words.delete();
    stim_words.push_back(vecs[v].w0);
    stim_words.push_back(vecs[v].w1);
    exp_addr_q.delete();
    exp_hi_q.delete();
    exp_lo_q.delete();
    if (vecs[v].exp_nwr >= 1) begin
      exp_addr_q.push_back(vecs[v].a0);
      exp_hi_q.push_back(vecs[v].hi0);
      exp_lo_q.push_back(vecs[v].lo0);
    end
    if (vecs[v].exp_nwr >= 2) begin
      exp_addr_q.push_back(vecs[v].a1);
      exp_hi_q.push_back(vecs[v].hi1);
      exp_lo_q.push_back(vecs[v].lo1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_load   = 1'b0;
    done_cnt  = 0;
    first_wr_cyc = -1;

    vecs[0] = '{14'h0010, 32'd2, 32'h12345678, 32'hDEADBEEF, 1'b0, 2,
                14'h0010, 16'h1234, 16'h5678, 14'h0011, 16'hDEAD, 16'hBEEF};
    vecs[1] = '{14'h0200, 32'd0, 32'h0, 32'h0, 1'b0, 0,
                14'h0, 16'h0, 16'h0, 14'h0, 16'h0, 16'h0};
    vecs[2] = '{14'h0300, 32'd16385, 32'h0, 32'h0, 1'b1, 0,
                14'h0, 16'h0, 16'h0, 14'h0, 16'h0, 16'h0};
    vecs[3] = '{14'h3FFF, 32'd2, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 2,
                14'h3FFF, 16'hCAFE, 16'hF00D, 14'h0000, 16'h0BAD, 16'hC0DE};
    vecs[4] = '{14'h0123, 32'd1, 32'hA5A55A5A, 32'h0, 1'b0, 1,
                14'h0123, 16'hA5A5, 16'h5A5A, 14'h0, 16'h0, 16'h0};

    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      run_load(vecs[v].base, vecs[v].n, 0, 1'b0, vecs[v].exp_err, $sformatf("vec%0d", v));
      check_writes($sformatf("vec%0d", v));
    end

    // Same load as vec0 with stalls and an ignored start mid-stream.
    load_vec(0);
    run_load(vecs[0].base, vecs[0].n, 3, 1'b1, 1'b0, "midstart");
    check_writes("midstart");

    for (int r = 0; r < 6; r++) begin
      logic [ADDR_W-1:0] base;
      int n;
      base = ADDR_W'($urandom);
      n    = int'($urandom_range(5, 1));
      stim_words.delete();
      exp_addr_q.delete();
      exp_hi_q.delete();
      exp_lo_q.delete();
      for (int k = 0; k < n; k++) begin
        logic [31:0] w;
        w = $urandom;
        stim_words.push_back(w);
        exp_addr_q.push_back(ADDR_W'((int'(base) + k) % (1 << ADDR_W)));
        exp_hi_q.push_back(w[31:16]);
        exp_lo_q.push_back(w[15:0]);
      end
      run_load(base, 32'(n), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b0,
               $sformatf("rnd%0d", r));
      check_writes($sformatf("rnd%0d", r));
    end

    // Reset after two bytes of the first data word.
    wr_addr_q.delete();
    wr_hi_q.delete();
    wr_lo_q.delete();
    base_addr = 14'h0020;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_load = 1'b1;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    in_load  = 1'b0;
    rst_n    = 1'b0;
    last_hi  = '0;
    last_lo  = '0;
    in_valid = 1'b1;
    in_data  = 8'h33;
    @(negedge clk);
    check_reset("rst_mid");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_nwr", 32'(wr_addr_q.size()), 32'd0);

    load_vec(4);
    run_load(vecs[4].base, vecs[4].n, 1, 1'b0, 1'b0, "post_rst");
    check_writes("post_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_corrupt = 1'b1;
    load_vec(0);
    run_load(vecs[0].base, vecs[0].n, 0, 1'b0, 1'b1, "bad_csum");
    check_writes("bad_csum");
    csum_corrupt = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
